// File: rtl/video_pkg.sv
// Shared video definitions: pixel packing, field offsets and line-timing defaults.
// Latency: none (types, constants and one pure function).
// Backpressure: none; strobe-driven design with no stall path.
package video_pkg;

  localparam int PIX_W  = 12;
  localparam int COMP_W = 4;
  localparam int G_LSB  = 8;   // G occupies [11:8]
  localparam int R_LSB  = 4;   // R occupies [7:4]
  localparam int B_LSB  = 0;   // B occupies [3:0]

  localparam int ADDR_W_DEF    = 9;
  localparam int HALF_LINE_DEF = 896;   // half of a 1792-clock TV line
  localparam int HSYNC_LEN_DEF = 96;

  typedef logic [PIX_W-1:0] pix_t;

  // Halve every colour field independently (no carry between fields).
  function automatic pix_t dim_pixel(input pix_t p);
    pix_t r;
    r = '0;
    r[G_LSB +: COMP_W] = p[G_LSB +: COMP_W] >> 1;
    r[R_LSB +: COMP_W] = p[R_LSB +: COMP_W] >> 1;
    r[B_LSB +: COMP_W] = p[B_LSB +: COMP_W] >> 1;
    return r;
  endfunction

endpackage

// File: rtl/video_scandbl_if.sv
// Bundle between the TV-rate pixel source/VGA sink and the scan doubler.
// Ports: tvcolor/tv_stb/rd_stb/line_start toward the doubler; vgacolor/vga_hsync/vga_rep back.
// Backpressure: none; all traffic is strobe qualified.
interface video_scandbl_if;
  import video_pkg::*;

  pix_t tvcolor;
  logic tv_stb;
  logic rd_stb;
  logic line_start;
  pix_t vgacolor;
  logic vga_hsync;
  logic vga_rep;

  modport master (
    output tvcolor, tv_stb, rd_stb, line_start,
    input  vgacolor, vga_hsync, vga_rep
  );

  modport slave (
    input  tvcolor, tv_stb, rd_stb, line_start,
    output vgacolor, vga_hsync, vga_rep
  );

endinterface

// File: rtl/video_scandbl_ram.sv
// Simple dual-port line-buffer RAM, 2**(ADDR_W+1) x PIX_W (two banks of one line each).
// Latency: read data registered, valid the clock after rd_en; write takes effect at the edge.
// Backpressure: none. Ports: clk, wr_en/wr_addr/wr_dat, rd_en/rd_addr -> rd_dat.
module video_scandbl_ram
  import video_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  pix_t            wr_dat,
  input  logic            rd_en,
  input  logic [ADDR_W:0] rd_addr,
  output pix_t            rd_dat
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  // Contents are never cleared: stale words are masked by the blanking
  // logic upstream, which keeps this mappable onto block RAM.
  pix_t mem [DEPTH];
  pix_t rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_dat_q <= mem[rd_addr];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/video_scandbl.sv
// VGA scan doubler: captures a TV line into a ping-pong buffer, replays the previous line twice.
// Latency: vgacolor updates 2 clocks after each rd_stb; hsync starts the clock after a VGA line start.
// Backpressure: none. Ports: clk, rst_n (sync, active low), bus (video_scandbl_if.slave).
// Optional macro VGA_SCANLINES_EN: halves every colour field on the second replay (vga_rep=1).
module video_scandbl
  import video_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int HALF_LINE = HALF_LINE_DEF,
  parameter int HSYNC_LEN = HSYNC_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  video_scandbl_if.slave bus
);

  localparam int HCNT_W = $clog2(HALF_LINE);
  localparam int SYNC_W = $clog2(HSYNC_LEN + 1);

  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HALF_LINE - 1);
  localparam logic [SYNC_W-1:0] SYNC_LOAD = SYNC_W'(HSYNC_LEN);

  logic              wr_bank_q,   wr_bank_d;
  logic              line_seen_q, line_seen_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] wr_len_q,    wr_len_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [HCNT_W-1:0] hcnt_q,      hcnt_d;
  logic [SYNC_W-1:0] sync_cnt_q,  sync_cnt_d;
  logic              vga_rep_q,   vga_rep_d;
  logic              vga_hsync_q, vga_hsync_d;
  logic              rd_vld_q,    rd_vld_d;
  logic              rd_blank_q,  rd_blank_d;
  pix_t              vgacolor_q,  vgacolor_d;
`ifdef VGA_SCANLINES_EN
  logic              rd_rep_q,    rd_rep_d;
`endif

  logic              line_restart;
  logic              ram_wr_en;
  logic [ADDR_W:0]   ram_wr_addr;
  logic [ADDR_W:0]   ram_rd_addr;
  pix_t              ram_rd_dat;
  pix_t              pix_shaded;

  video_scandbl_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_dat  (bus.tvcolor),
    .rd_en   (bus.rd_stb),
    .rd_addr (ram_rd_addr),
    .rd_dat  (ram_rd_dat)
  );

`ifdef VGA_SCANLINES_EN
  assign pix_shaded = rd_rep_q ? dim_pixel(ram_rd_dat) : ram_rd_dat;
`else
  assign pix_shaded = ram_rd_dat;
`endif

  always_comb begin
    wr_bank_d   = wr_bank_q;
    line_seen_d = line_seen_q;
    wr_ptr_d    = wr_ptr_q;
    wr_len_d    = wr_len_q;
    rd_ptr_d    = rd_ptr_q;
    hcnt_d      = hcnt_q;
    sync_cnt_d  = sync_cnt_q;
    vga_rep_d   = vga_rep_q;
    vga_hsync_d = vga_hsync_q;
    rd_vld_d    = bus.rd_stb;
    rd_blank_d  = rd_blank_q;
    vgacolor_d  = vgacolor_q;
`ifdef VGA_SCANLINES_EN
    rd_rep_d    = rd_rep_q;
`endif
    ram_wr_en   = 1'b0;
    ram_wr_addr = {wr_bank_q, wr_ptr_q};
    ram_rd_addr = {~wr_bank_q, rd_ptr_q};

    // Write side. A pixel arriving with line_start belongs to the new line,
    // so it lands at address 0 of the bank being switched to.
    if (bus.line_start) begin
      // The first line after reset was entered mid-way; show it as empty.
      wr_len_d    = line_seen_q ? wr_ptr_q : '0;
      line_seen_d = 1'b1;
      wr_bank_d   = ~wr_bank_q;
      if (bus.tv_stb) begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = {~wr_bank_q, {ADDR_W{1'b0}}};
        wr_ptr_d    = ADDR_W'(1);
      end else begin
        wr_ptr_d    = '0;
      end
    end else if (bus.tv_stb) begin
      ram_wr_en = 1'b1;
      if (wr_ptr_q != PTR_MAX) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end

    // Read side: the blank decision travels alongside the RAM access.
    if (bus.rd_stb) begin
      rd_blank_d = (rd_ptr_q >= wr_len_q);
`ifdef VGA_SCANLINES_EN
      rd_rep_d   = vga_rep_q;
`endif
      if (rd_ptr_q != PTR_MAX) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
    end

    // Half-line sequencer; line_start takes priority over the wrap.
    line_restart = bus.line_start || (hcnt_q == HCNT_LAST);
    if (bus.line_start) begin
      hcnt_d    = '0;
      rd_ptr_d  = '0;
      vga_rep_d = 1'b0;
    end else if (hcnt_q == HCNT_LAST) begin
      hcnt_d    = '0;
      rd_ptr_d  = '0;
      vga_rep_d = ~vga_rep_q;
    end else begin
      hcnt_d    = hcnt_q + HCNT_W'(1);
    end

    // sync_cnt holds the clocks of pulse still to show, including the current one.
    if (line_restart) begin
      sync_cnt_d  = SYNC_LOAD;
      vga_hsync_d = 1'b1;
    end else if (sync_cnt_q > SYNC_W'(1)) begin
      sync_cnt_d  = sync_cnt_q - SYNC_W'(1);
      vga_hsync_d = 1'b1;
    end else begin
      sync_cnt_d  = '0;
      vga_hsync_d = 1'b0;
    end

    if (rd_vld_q) begin
      vgacolor_d = rd_blank_q ? '0 : pix_shaded;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      line_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      wr_len_q    <= '0;
      rd_ptr_q    <= '0;
      hcnt_q      <= '0;
      sync_cnt_q  <= '0;
      vga_rep_q   <= 1'b0;
      vga_hsync_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_blank_q  <= 1'b1;
      vgacolor_q  <= '0;
`ifdef VGA_SCANLINES_EN
      rd_rep_q    <= 1'b0;
`endif
    end else begin
      wr_bank_q   <= wr_bank_d;
      line_seen_q <= line_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_len_q    <= wr_len_d;
      rd_ptr_q    <= rd_ptr_d;
      hcnt_q      <= hcnt_d;
      sync_cnt_q  <= sync_cnt_d;
      vga_rep_q   <= vga_rep_d;
      vga_hsync_q <= vga_hsync_d;
      rd_vld_q    <= rd_vld_d;
      rd_blank_q  <= rd_blank_d;
      vgacolor_q  <= vgacolor_d;
`ifdef VGA_SCANLINES_EN
      rd_rep_q    <= rd_rep_d;
`endif
    end
  end

  assign bus.vgacolor  = vgacolor_q;
  assign bus.vga_hsync = vga_hsync_q;
  assign bus.vga_rep   = vga_rep_q;

endmodule

// File: tb/tb_video_scandbl.sv
// Bench for video_scandbl: reference model of the doubler plus directed line scenarios.
module tb_video_scandbl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_scandbl_if bus ();

  video_scandbl #(.ADDR_W(9), .HALF_LINE(896), .HSYNC_LEN(96)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Lines are kept as queues of pixels; the displayed line is the last
  // completed one, clipped to 511 visible pixels.
  logic [11:0] cap[$];
  logic [11:0] shown[$];
  bit          seen_m, rep_m, p_vld, started;
  int          rd_idx, phase, sync_left, vis;
  logic [11:0] p_val, exp_color;

  function automatic logic [11:0] halve(input logic [11:0] p);
    int g, r, b;
    g = (int'(p) / 256) % 16;
    r = (int'(p) / 16) % 16;
    b = int'(p) % 16;
    return 12'((g / 2) * 256 + (r / 2) * 16 + (b / 2));
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      cap.delete(); shown.delete();
      seen_m = 0; rep_m = 0; p_vld = 0;
      rd_idx = 0; phase = 0; sync_left = 0;
      exp_color = 12'h000;
    end else begin
      if (p_vld) exp_color = p_val;
      p_vld = bus.rd_stb;
      if (bus.rd_stb) begin
        vis = (shown.size() > 511) ? 511 : shown.size();
        p_val = (rd_idx < vis) ? shown[rd_idx] : 12'h000;
`ifdef VGA_SCANLINES_EN
        if (rep_m) p_val = halve(p_val);
`endif
      end
      if (bus.line_start) begin
        if (seen_m) shown = cap; else shown.delete();
        seen_m = 1;
        cap.delete();
        if (bus.tv_stb) cap.push_back(bus.tvcolor);
        rd_idx = 0; phase = 0; rep_m = 0; sync_left = 96;
      end else begin
        if (bus.tv_stb) begin
          if (cap.size() < 512) cap.push_back(bus.tvcolor);
          else cap[511] = bus.tvcolor;
        end
        if (bus.rd_stb && rd_idx < 511) rd_idx++;
        if (sync_left > 0) sync_left--;
        if (phase == 895) begin
          phase = 0; rd_idx = 0; rep_m = ~rep_m; sync_left = 96;
        end else begin
          phase++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("vgacolor", int'(bus.vgacolor), int'(exp_color));
      check("vga_hsync", int'(bus.vga_hsync), (sync_left > 0) ? 1 : 0);
      check("vga_rep", int'(bus.vga_rep), int'(rep_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line();
    bus.line_start = 1'b1;
    step();
    bus.line_start = 1'b0;
  endtask

  task automatic wr_px(input logic [11:0] v);
    bus.tv_stb  = 1'b1;
    bus.tvcolor = v;
    step();
    bus.tv_stb  = 1'b0;
  endtask

  task automatic rd_px(output logic [11:0] v);
    bus.rd_stb = 1'b1;
    step();
    bus.rd_stb = 1'b0;
    step();
    v = bus.vgacolor;
  endtask

  task automatic wait_rep(input logic val);
    int k;
    k = 0;
    while (bus.vga_rep !== val && k < 2000) begin
      step();
      k++;
    end
    check("wait_vga_rep", int'(bus.vga_rep), int'(val));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v;
    int hi, t;
    bus.tvcolor = 12'h000;
    bus.tv_stb = 1'b0;
    bus.rd_stb = 1'b0;
    bus.line_start = 1'b0;
    rst_n = 1'b0;

    // Reset with strobes toggling.
    for (int i = 0; i < 3; i++) begin
      bus.tv_stb = ~bus.tv_stb;
      bus.rd_stb = ~bus.rd_stb;
      bus.line_start = ~bus.line_start;
      bus.tvcolor = 12'h5A5;
      step();
    end
    check("rst_vgacolor", int'(bus.vgacolor), 0);
    check("rst_hsync", int'(bus.vga_hsync), 0);
    check("rst_rep", int'(bus.vga_rep), 0);
    bus.tv_stb = 1'b0; bus.rd_stb = 1'b0; bus.line_start = 1'b0;
    rst_n = 1'b1;

    // Partial line after reset is discarded.
    wr_px(12'h0AA);
    wr_px(12'h0BB);
    pulse_line();
    rd_px(v); check("post_rst_px0", int'(v), 0);
    rd_px(v); check("post_rst_px1", int'(v), 0);

    // Capture ten pixels and replay twice.
    pulse_line();
    for (int i = 1; i <= 10; i++) wr_px(12'(i));
    pulse_line();
    for (int i = 1; i <= 11; i++) begin
      rd_px(v);
      check("replay0", int'(v), (i <= 10) ? i : 0);
    end
    wait_rep(1'b1);
    for (int i = 1; i <= 11; i++) begin
      rd_px(v);
      check("replay1", int'(v), (i <= 10) ? i : 0);
    end

    // Sync width and period after line_start.
    pulse_line();
    hi = 0;
    while (bus.vga_hsync && hi < 300) begin hi++; step(); end
    check("hsync_width", hi, 96);
    t = hi;
    while (!bus.vga_hsync && t < 2000) begin step(); t++; end
    check("hsync_period_ls", t, 896);

    // Free-running pulses with no line_start.
    t = 0;
    while (bus.vga_hsync && t < 2000) begin step(); t++; end
    while (!bus.vga_hsync && t < 2000) begin step(); t++; end
    check("hsync_period_free", t, 896);
    repeat (2200) step();

    // line_start colliding with tv_stb.
    pulse_line();
    wr_px(12'h111); wr_px(12'h222); wr_px(12'h333);
    bus.line_start = 1'b1; bus.tv_stb = 1'b1; bus.tvcolor = 12'hFFF;
    step();
    bus.line_start = 1'b0; bus.tv_stb = 1'b0;
    rd_px(v); check("coll_a0", int'(v), 12'h111);
    rd_px(v); check("coll_a1", int'(v), 12'h222);
    rd_px(v); check("coll_a2", int'(v), 12'h333);
    rd_px(v); check("coll_a3", int'(v), 12'h000);
    wr_px(12'h444);
    pulse_line();
    rd_px(v); check("coll_b0", int'(v), 12'hFFF);
    rd_px(v); check("coll_b1", int'(v), 12'h444);
    rd_px(v); check("coll_b2", int'(v), 12'h000);

    // Overflow: 600 writes, 511 visible pixels.
    pulse_line();
    for (int i = 0; i < 600; i++) begin
      bus.tv_stb = 1'b1;
      bus.tvcolor = 12'(i);
      step();
    end
    bus.tv_stb = 1'b0;
    pulse_line();
    bus.rd_stb = 1'b1;
    for (int j = 1; j <= 514; j++) begin
      step();
      if (j == 3)   check("ovf_px1", int'(bus.vgacolor), 12'h001);
      if (j == 512) check("ovf_px510", int'(bus.vgacolor), 12'h1FE);
      if (j == 513) check("ovf_px511", int'(bus.vgacolor), 12'h000);
      if (j == 514) check("ovf_sat", int'(bus.vgacolor), 12'h000);
    end
    bus.rd_stb = 1'b0;

    // Second-replay shading.
    pulse_line();
    wr_px(12'hF84);
    pulse_line();
    rd_px(v); check("scan_rep0", int'(v), 12'hF84);
    wait_rep(1'b1);
    rd_px(v);
`ifdef VGA_SCANLINES_EN
    check("scan_rep1", int'(v), 12'h742);
`else
    check("scan_rep1", int'(v), 12'hF84);
`endif

    // Mid-line reset discards buffered content.
    pulse_line();
    wr_px(12'h0C0);
    wr_px(12'h0D0);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("midrst_color", int'(bus.vgacolor), 0);
    wr_px(12'h123);
    pulse_line();
    rd_px(v); check("midrst_px0", int'(v), 0);

    step(); step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
